// File: rtl/mmu_arbiter.sv
// Shares one memory port between instruction fetch and data load/store channels.
// Optional anti-starvation guard for fetches is enabled by defining MMU_ARB_STARVE_GUARD_EN.
module mmu_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_ROADDR,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WRADDR,
    input  logic [31:0] DATA_WRDATA,
    input  logic [3:0]  DATA_WRSTRB,
    output logic        DATA_WDONE,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_STRB,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT_I = 3'd1,
        GNT_R = 3'd2,
        GNT_W = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state;
    logic   flushed;
    logic   inst_valid_q;
    logic   force_inst;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mmu_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef MMU_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_inst = INST_RDEN && (starve_cnt == 4'(STARVE_LIMIT));

    // Counts data grants that bypassed a waiting fetch; any fetch grant or idle fetch clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!INST_RDEN || force_inst || !(DATA_WREN || DATA_RDEN)) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'd15) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign force_inst = 1'b0;
`endif

    assign MEM_WAIT    = (state == GNT_I) || (state == GNT_R) || (state == GNT_W);
    // A flush during the response cycle itself must still kill the pulse.
    assign INST_RVALID = inst_valid_q & ~FLUSH;
    assign dbg_state   = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            flushed      <= 1'b0;
            inst_valid_q <= 1'b0;
            DATA_RVALID  <= 1'b0;
            DATA_WDONE   <= 1'b0;
            MEM_REQ      <= 1'b0;
            MEM_WE       <= 1'b0;
            MEM_ADDR     <= 32'd0;
            MEM_WDATA    <= 32'd0;
            MEM_STRB     <= 4'd0;
            INST_ROADDR  <= 32'd0;
            INST_RDATA   <= 32'd0;
            DATA_ROADDR  <= 32'd0;
            DATA_RDATA   <= 32'd0;
        end else begin
            inst_valid_q <= 1'b0;
            DATA_RVALID  <= 1'b0;
            DATA_WDONE   <= 1'b0;
            case (state)
                IDLE: begin
                    if (force_inst || (INST_RDEN && !DATA_WREN && !DATA_RDEN)) begin
                        state     <= GNT_I;
                        flushed   <= 1'b0;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= 1'b0;
                        MEM_ADDR  <= INST_RIADDR;
                        MEM_WDATA <= 32'd0;
                        MEM_STRB  <= 4'd0;
                    end else if (DATA_WREN) begin
                        state     <= GNT_W;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= DATA_WRADDR;
                        MEM_WDATA <= DATA_WRDATA;
                        MEM_STRB  <= DATA_WRSTRB;
                    end else if (DATA_RDEN) begin
                        state     <= GNT_R;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= 1'b0;
                        MEM_ADDR  <= DATA_RIADDR;
                        MEM_WDATA <= 32'd0;
                        MEM_STRB  <= 4'd0;
                    end
                end
                GNT_I, GNT_R, GNT_W: begin
                    if (state == GNT_I && FLUSH) begin
                        flushed <= 1'b1;
                    end
                    if (MEM_ACK) begin
                        state   <= RESP;
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        case (state)
                            GNT_I: begin
                                inst_valid_q <= ~(flushed | FLUSH);
                                INST_ROADDR  <= MEM_ADDR;
                                INST_RDATA   <= MEM_RDATA;
                            end
                            GNT_R: begin
                                DATA_RVALID <= 1'b1;
                                DATA_ROADDR <= MEM_ADDR;
                                DATA_RDATA  <= MEM_RDATA;
                            end
                            default: begin
                                DATA_WDONE <= 1'b1;
                            end
                        endcase
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration and response rules.
module tb_mmu_arbiter;

  localparam int STARVE = 2;
`ifdef MMU_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic CLK = 1'b0;
  logic RST, FLUSH, INST_RDEN, DATA_RDEN, DATA_WREN, MEM_ACK;
  logic [31:0] INST_RIADDR, DATA_RIADDR, DATA_WRADDR, DATA_WRDATA, MEM_RDATA;
  logic [3:0] DATA_WRSTRB;
  logic INST_RVALID, DATA_RVALID, DATA_WDONE, MEM_WAIT, MEM_REQ, MEM_WE;
  logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA, MEM_ADDR, MEM_WDATA;
  logic [3:0] MEM_STRB;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  mmu_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RVALID(INST_RVALID),
    .INST_ROADDR(INST_ROADDR), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_RVALID(DATA_RVALID),
    .DATA_ROADDR(DATA_ROADDR), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WRADDR(DATA_WRADDR), .DATA_WRDATA(DATA_WRDATA),
    .DATA_WRSTRB(DATA_WRSTRB), .DATA_WDONE(DATA_WDONE),
    .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_STRB(MEM_STRB), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] grant_log[$];
  int ival_cnt, dval_cnt, wdone_cnt, wait_cnt, req_cnt;
  logic prev_req = 1'b0;
  int be_delay = 0;

  // Reference model: one outstanding transaction, phase 0=free, 1=awaiting ack, 2=response.
  int m_phase, m_kind, m_cnt;
  bit m_flushed;
  logic e_req, e_we, e_ival, e_dval, e_wdone;
  logic [31:0] e_addr, e_wdata, e_iroaddr, e_irdata, e_droaddr, e_drdata;
  logic [3:0] e_strb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_kind = 0; m_cnt = 0; m_flushed = 0;
    e_req = 0; e_we = 0; e_ival = 0; e_dval = 0; e_wdone = 0;
    e_addr = 0; e_wdata = 0; e_strb = 0;
    e_iroaddr = 0; e_irdata = 0; e_droaddr = 0; e_drdata = 0;
  endtask

  // Applies the arbitration rules to the inputs sampled at one rising edge.
  task automatic model_step();
    int kind;
    if (RST) begin
      model_reset();
      return;
    end
    e_ival = 0; e_dval = 0; e_wdone = 0;
    case (m_phase)
      0: begin
        kind = 0;
        if (GUARD && INST_RDEN && m_cnt == STARVE) kind = 1;
        else if (DATA_WREN) kind = 3;
        else if (DATA_RDEN) kind = 2;
        else if (INST_RDEN) kind = 1;
        if (GUARD) begin
          if (!INST_RDEN || kind == 1) m_cnt = 0;
          else if (m_cnt < 15) m_cnt++;
        end
        if (kind != 0) begin
          m_kind = kind; m_phase = 1; m_flushed = 0;
          e_req = 1; e_we = (kind == 3);
          e_addr = (kind == 3) ? DATA_WRADDR : (kind == 2) ? DATA_RIADDR : INST_RIADDR;
          e_wdata = DATA_WRDATA; e_strb = DATA_WRSTRB;
        end
      end
      1: begin
        if (m_kind == 1 && FLUSH) m_flushed = 1;
        if (MEM_ACK) begin
          e_req = 0; e_we = 0; m_phase = 2;
          if (m_kind == 1) begin
            e_ival = !m_flushed; e_iroaddr = e_addr; e_irdata = MEM_RDATA;
          end else if (m_kind == 2) begin
            e_dval = 1; e_droaddr = e_addr; e_drdata = MEM_RDATA;
          end else begin
            e_wdone = 1;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("mem_req", MEM_REQ, e_req);
    check("mem_we", MEM_WE, e_we);
    check("mem_wait", MEM_WAIT, m_phase == 1);
    check("mem_addr", MEM_ADDR, e_addr);
    if (e_req && e_we) begin
      check("mem_wdata", MEM_WDATA, e_wdata);
      check("mem_strb", MEM_STRB, e_strb);
    end
    check("inst_rvalid", INST_RVALID, e_ival & ~FLUSH);
    check("data_rvalid", DATA_RVALID, e_dval);
    check("data_wdone", DATA_WDONE, e_wdone);
    if (e_ival) begin
      check("inst_roaddr", INST_ROADDR, e_iroaddr);
      check("inst_rdata", INST_RDATA, e_irdata);
    end
    if (e_dval) begin
      check("data_roaddr", DATA_ROADDR, e_droaddr);
      check("data_rdata", DATA_RDATA, e_drdata);
    end
  endtask

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    if (MEM_REQ && !prev_req) grant_log.push_back(MEM_ADDR);
    prev_req = MEM_REQ;
    ival_cnt += int'(INST_RVALID);
    dval_cnt += int'(DATA_RVALID);
    wdone_cnt += int'(DATA_WDONE);
    wait_cnt += int'(MEM_WAIT);
    req_cnt += int'(MEM_REQ);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic clear_stats();
    ival_cnt = 0; dval_cnt = 0; wdone_cnt = 0; wait_cnt = 0; req_cnt = 0;
    grant_log.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_all();
    INST_RDEN = 0; DATA_RDEN = 0; DATA_WREN = 0; FLUSH = 0; MEM_ACK = 0;
  endtask

  task automatic backend_drive();
    if (MEM_REQ) begin
      if (be_delay == 0) begin
        MEM_ACK = 1; MEM_RDATA = $urandom; be_delay = $urandom_range(0, 3);
      end else begin
        MEM_ACK = 0; be_delay--;
      end
    end else begin
      MEM_ACK = ($urandom_range(0, 15) == 0);
      MEM_RDATA = $urandom;
    end
  endtask

  task automatic requesters_react(input bit rnd);
    if (DATA_WREN && DATA_WDONE) DATA_WREN = 0;
    else if (rnd && !DATA_WREN && $urandom_range(0, 3) == 0) begin
      DATA_WREN = 1; DATA_WRADDR = $urandom; DATA_WRDATA = $urandom;
      DATA_WRSTRB = 4'($urandom_range(1, 15));
    end else if (rnd && DATA_WREN && !(m_phase != 0 && m_kind == 3) && $urandom_range(0, 15) == 0)
      DATA_WREN = 0;
    if (DATA_RDEN && DATA_RVALID) DATA_RDEN = 0;
    else if (rnd && !DATA_RDEN && $urandom_range(0, 3) == 0) begin
      DATA_RDEN = 1; DATA_RIADDR = $urandom;
    end else if (rnd && DATA_RDEN && !(m_phase != 0 && m_kind == 2) && $urandom_range(0, 15) == 0)
      DATA_RDEN = 0;
    if (INST_RDEN && INST_RVALID) INST_RDEN = 0;
    else if (rnd && !INST_RDEN && $urandom_range(0, 2) == 0) begin
      INST_RDEN = 1; INST_RIADDR = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int loads_before;
    bit fetch_seen;
    logic [31:0] got;
    RST = 1; drop_all();
    INST_RIADDR = 0; DATA_RIADDR = 0; DATA_WRADDR = 0; DATA_WRDATA = 0; DATA_WRSTRB = 0;
    MEM_RDATA = 0;
    model_reset();
    @(negedge CLK);
    tick();
    RST = 0;
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_mem_we", MEM_WE, 0);
    check("rst_mem_wait", MEM_WAIT, 0);
    check("rst_inst_rvalid", INST_RVALID, 0);
    check("rst_data_rvalid", DATA_RVALID, 0);
    check("rst_data_wdone", DATA_WDONE, 0);
    check("rst_mem_addr", MEM_ADDR, 0);
    check("rst_mem_wdata", MEM_WDATA, 0);
    check("rst_mem_strb", MEM_STRB, 0);
    check("rst_inst_ro", INST_ROADDR | INST_RDATA, 0);
    check("rst_data_ro", DATA_ROADDR | DATA_RDATA, 0);
    check("rst_state", dbg_state, 0);
    tick();

    // Single fetch, ACK two cycles after the grant.
    clear_stats();
    INST_RDEN = 1; INST_RIADDR = 32'h100;
    tick();
    tick();
    MEM_ACK = 1; MEM_RDATA = 32'hDEADBEEF;
    tick();
    MEM_ACK = 0; INST_RDEN = 0;
    check("fetch_rvalid", INST_RVALID, 1);
    check("fetch_roaddr", INST_ROADDR, 32'h100);
    check("fetch_rdata", INST_RDATA, 32'hDEADBEEF);
    tick(); tick();
    check("fetch_pulses", ival_cnt, 1);
    check("fetch_wait_cycles", wait_cnt, 2);

    // Priority: store > load > fetch, all raised together.
    clear_stats();
    DATA_WREN = 1; DATA_WRADDR = 32'h200; DATA_WRDATA = 32'h12345678; DATA_WRSTRB = 4'hF;
    DATA_RDEN = 1; DATA_RIADDR = 32'h300;
    INST_RDEN = 1; INST_RIADDR = 32'h104;
    exp_q.push_back(32'h200); exp_q.push_back(32'h300); exp_q.push_back(32'h104);
    be_delay = 0;
    for (int c = 0; c < 40; c++) begin
      backend_drive();
      requesters_react(1'b0);
      tick();
    end
    drop_all();
    for (int i = 0; i < 3; i++) begin
      got = (grant_log.size() > 0) ? grant_log.pop_front() : 32'hFFFF_FFFF;
      check("prio_grant_order", got, exp_q.pop_front());
    end
    check("prio_extra_grants", grant_log.size(), 0);
    check("prio_wdone", wdone_cnt, 1);
    check("prio_rvalid", dval_cnt, 1);
    check("prio_ivalid", ival_cnt, 1);

    // Flush one cycle before the fetch ACK.
    tick();
    clear_stats();
    INST_RDEN = 1; INST_RIADDR = 32'h108;
    tick();
    tick();
    FLUSH = 1;
    tick();
    FLUSH = 0; MEM_ACK = 1; MEM_RDATA = 32'hCAFEF00D;
    tick();
    MEM_ACK = 0; INST_RDEN = 0;
    tick(); tick();
    check("flush_no_ivalid", ival_cnt, 0);
    check("flush_req_cycles", req_cnt, 3);

    // Reset while a load is granted, then a late ACK.
    clear_stats();
    DATA_RDEN = 1; DATA_RIADDR = 32'h300;
    tick();
    RST = 1;
    tick();
    RST = 0; MEM_ACK = 1; DATA_RDEN = 0;
    check("rstmid_mem_req", MEM_REQ, 0);
    check("rstmid_mem_addr", MEM_ADDR, 0);
    check("rstmid_state", dbg_state, 0);
    tick();
    MEM_ACK = 0;
    tick();
    // Reset coinciding with the ACK.
    DATA_RDEN = 1; DATA_RIADDR = 32'h304;
    tick();
    RST = 1; MEM_ACK = 1;
    tick();
    RST = 0; MEM_ACK = 0; DATA_RDEN = 0;
    tick(); tick();
    check("rstmid_no_rvalid", dval_cnt, 0);

    // Starvation: loads held continuously with a pending fetch.
    clear_stats();
    INST_RDEN = 1; INST_RIADDR = 32'h400;
    DATA_RDEN = 1; DATA_RIADDR = 32'h300;
    be_delay = 0; loads_before = 0; fetch_seen = 0;
    for (int c = 0; c < 80 && !fetch_seen && loads_before < 8; c++) begin
      backend_drive();
      tick();
      while (grant_log.size() > 0) begin
        got = grant_log.pop_front();
        if (got == 32'h400) fetch_seen = 1;
        else if (!fetch_seen) loads_before++;
      end
    end
`ifdef MMU_ARB_STARVE_GUARD_EN
    check("starve_fetch_granted", fetch_seen, 1);
    check("starve_loads_before_fetch", loads_before, STARVE);
`else
    check("nostarve_fetch_granted", fetch_seen, 0);
    check("nostarve_load_grants", loads_before, 8);
`endif
    drop_all();
    for (int c = 0; c < 10; c++) begin
      backend_drive();
      tick();
    end

    // Randomized traffic with flushes, stray ACKs and occasional resets.
    drop_all();
    for (int c = 0; c < 3000; c++) begin
      backend_drive();
      requesters_react(1'b1);
      FLUSH = ($urandom_range(0, 9) == 0);
      RST = ($urandom_range(0, 99) == 0);
      tick();
    end
    RST = 0; drop_all();
    for (int c = 0; c < 10; c++) begin
      backend_drive();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
